// File: rtl/hazard_stall_ctrl_if.sv
// Issue-control bundle between the ID-stage instruction register and hazard_stall_ctrl.
// The master side presents the instruction in IF/ID; the slave side returns the stall, bubble and MDU-busy controls.
interface hazard_stall_ctrl_if;
    logic [31:0] instr_Id;
    logic        ifStall;
    logic        idExFlush;
    logic        mduBusy;

    modport master (
        output instr_Id,
        input  ifStall,
        input  idExFlush,
        input  mduBusy
    );

    modport slave (
        input  instr_Id,
        output ifStall,
        output idExFlush,
        output mduBusy
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/bubble controller for the five-stage MIPS pipeline: Tuse/Tnew scoreboard over the EX and MEM slots.
// Define MDU_STALL_EN to include the multiply/divide busy counter and its stall term.
module hazard_stall_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic               clk,
    input  logic               reset,
    hazard_stall_ctrl_if.slave bus
);

    logic [5:0] op_s;
    logic [5:0] funct_s;
    logic [4:0] rs_s;
    logic [4:0] rt_s;
    logic [4:0] rd_s;
    logic       is_r_s;

    assign op_s    = bus.instr_Id[31:26];
    assign rs_s    = bus.instr_Id[25:21];
    assign rt_s    = bus.instr_Id[20:16];
    assign rd_s    = bus.instr_Id[15:11];
    assign funct_s = bus.instr_Id[5:0];
    assign is_r_s  = (op_s == 6'h00);

    // The shamt field never takes part in hazard decisions.
    logic shamt_unused_s;
    assign shamt_unused_s = ^bus.instr_Id[10:6];

    logic r_alu_s;
    logic r_jr_s;
    logic r_jalr_s;
    logic r_mfhilo_s;
    logic r_mthilo_s;
    logic r_muldiv_s;
    logic r_mdu_s;

    // R-format function classification
    always_comb begin
        r_alu_s    = 1'b0;
        r_jr_s     = 1'b0;
        r_jalr_s   = 1'b0;
        r_mfhilo_s = 1'b0;
        r_mthilo_s = 1'b0;
        r_muldiv_s = 1'b0;
        if (is_r_s) begin
            case (funct_s)
                6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                6'h26, 6'h27, 6'h2a, 6'h2b: r_alu_s    = 1'b1;
                6'h08:                      r_jr_s     = 1'b1;
                6'h09:                      r_jalr_s   = 1'b1;
                6'h10, 6'h12:               r_mfhilo_s = 1'b1;
                6'h11, 6'h13:               r_mthilo_s = 1'b1;
                6'h18, 6'h19, 6'h1a, 6'h1b: r_muldiv_s = 1'b1;
                default:                    r_alu_s    = 1'b0;
            endcase
        end else begin
            r_alu_s = 1'b0;
        end
    end

    assign r_mdu_s = r_muldiv_s | r_mfhilo_s | r_mthilo_s;

    logic i_alu_s;
    logic i_lui_s;
    logic i_load_s;
    logic i_store_s;
    logic i_branch_s;
    logic i_jal_s;

    // Opcode classification of I- and J-format instructions
    always_comb begin
        i_alu_s    = 1'b0;
        i_lui_s    = 1'b0;
        i_load_s   = 1'b0;
        i_store_s  = 1'b0;
        i_branch_s = 1'b0;
        i_jal_s    = 1'b0;
        case (op_s)
            6'h08, 6'h09, 6'h0a, 6'h0b,
            6'h0c, 6'h0d, 6'h0e:        i_alu_s    = 1'b1;
            6'h0f:                      i_lui_s    = 1'b1;
            6'h20, 6'h21, 6'h23:        i_load_s   = 1'b1;
            6'h28, 6'h29, 6'h2b:        i_store_s  = 1'b1;
            6'h04, 6'h05:               i_branch_s = 1'b1;
            6'h03:                      i_jal_s    = 1'b1;
            default:                    i_alu_s    = 1'b0;
        endcase
    end

    logic       use_rs_s;
    logic [1:0] tuse_rs_s;
    logic       use_rt_s;
    logic [1:0] tuse_rt_s;
    logic [4:0] dest_s;
    logic [1:0] tnew_s;

    // Source deadlines (Tuse) and result availability (TnewE) of the instruction in ID
    always_comb begin
        use_rs_s  = 1'b0;
        tuse_rs_s = 2'd0;
        use_rt_s  = 1'b0;
        tuse_rt_s = 2'd0;
        dest_s    = 5'd0;
        tnew_s    = 2'd0;

        if (i_branch_s || r_jr_s || r_jalr_s) begin
            use_rs_s  = 1'b1;
            tuse_rs_s = 2'd0;
        end else if (r_alu_s || i_alu_s || i_load_s || i_store_s || r_muldiv_s || r_mthilo_s) begin
            use_rs_s  = 1'b1;
            tuse_rs_s = 2'd1;
        end else begin
            use_rs_s  = 1'b0;
        end

        if (i_branch_s) begin
            use_rt_s  = 1'b1;
            tuse_rt_s = 2'd0;
        end else if (r_alu_s || r_muldiv_s) begin
            use_rt_s  = 1'b1;
            tuse_rt_s = 2'd1;
        end else if (i_store_s) begin
            use_rt_s  = 1'b1;
            tuse_rt_s = 2'd2;
        end else begin
            use_rt_s  = 1'b0;
        end

        if (r_alu_s || r_mfhilo_s) begin
            dest_s = rd_s;
            tnew_s = 2'd1;
        end else if (i_alu_s || i_lui_s) begin
            dest_s = rt_s;
            tnew_s = 2'd1;
        end else if (i_load_s) begin
            dest_s = rt_s;
            tnew_s = 2'd2;
        end else if (i_jal_s) begin
            dest_s = 5'd31;
            tnew_s = 2'd0;
        end else if (r_jalr_s) begin
            dest_s = rd_s;
            tnew_s = 2'd0;
        end else begin
            dest_s = 5'd0;
            tnew_s = 2'd0;
        end
    end

    logic [4:0] dest_e_r;
    logic [1:0] tnew_e_r;
    logic [4:0] dest_m_r;
    logic [1:0] tnew_m_r;

    // A source is blocked when an in-flight producer still needs more cycles than the consumer can wait.
    function automatic logic raw_hit(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] dst,
        input logic [1:0] tnew
    );
        raw_hit = (dst != 5'd0) && (src == dst) && (tnew > tuse);
    endfunction

    logic rs_hazard_s;
    logic rt_hazard_s;
    logic mdu_stall_s;
    logic mdu_busy_s;
    logic stall_s;

    assign rs_hazard_s = use_rs_s &&
                         (raw_hit(rs_s, tuse_rs_s, dest_e_r, tnew_e_r) ||
                          raw_hit(rs_s, tuse_rs_s, dest_m_r, tnew_m_r));
    assign rt_hazard_s = use_rt_s &&
                         (raw_hit(rt_s, tuse_rt_s, dest_e_r, tnew_e_r) ||
                          raw_hit(rt_s, tuse_rt_s, dest_m_r, tnew_m_r));
    assign stall_s     = rs_hazard_s | rt_hazard_s | mdu_stall_s;

    // Scoreboard shift: E takes the issuing instruction or a bubble, M ages E by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            dest_e_r <= 5'd0;
            tnew_e_r <= 2'd0;
            dest_m_r <= 5'd0;
            tnew_m_r <= 2'd0;
        end else begin
            dest_m_r <= dest_e_r;
            tnew_m_r <= (tnew_e_r != 2'd0) ? (tnew_e_r - 2'd1) : 2'd0;
            if (stall_s) begin
                dest_e_r <= 5'd0;
                tnew_e_r <= 2'd0;
            end else begin
                dest_e_r <= dest_s;
                tnew_e_r <= tnew_s;
            end
        end
    end

`ifdef MDU_STALL_EN
    logic [3:0] mdu_cnt_r;
    logic [3:0] mdu_cnt_next_s;
    logic       mdu_busy_r;

    // Busy countdown; a mult/div can only issue while idle, so loading never races a decrement
    always_comb begin
        mdu_cnt_next_s = mdu_cnt_r;
        if (!stall_s && r_muldiv_s) begin
            mdu_cnt_next_s = funct_s[1] ? 4'(DIV_LAT) : 4'(MULT_LAT);
        end else if (mdu_cnt_r != 4'd0) begin
            mdu_cnt_next_s = mdu_cnt_r - 4'd1;
        end else begin
            mdu_cnt_next_s = 4'd0;
        end
    end

    // Counter and its busy flag are registered together so mduBusy comes straight from a flop
    always_ff @(posedge clk) begin
        if (reset) begin
            mdu_cnt_r  <= 4'd0;
            mdu_busy_r <= 1'b0;
        end else begin
            mdu_cnt_r  <= mdu_cnt_next_s;
            mdu_busy_r <= (mdu_cnt_next_s != 4'd0);
        end
    end

    assign mdu_busy_s  = mdu_busy_r;
    assign mdu_stall_s = mdu_busy_r & r_mdu_s;
`else
    // Without the busy counter the latencies and the hi/lo class play no role.
    logic mdu_unused_s;
    assign mdu_unused_s = ^{4'(MULT_LAT), 4'(DIV_LAT), r_mdu_s};
    assign mdu_busy_s   = 1'b0;
    assign mdu_stall_s  = 1'b0;
`endif

    assign bus.ifStall   = stall_s;
    assign bus.idExFlush = stall_s;
    assign bus.mduBusy   = mdu_busy_s;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed hazard scenarios plus random instruction streams
// compared against an issue-history model (producer age vs. consumer deadline).
module tb_hazard_stall_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
`ifdef MDU_STALL_EN
    localparam int MDU_ON = 1;
`else
    localparam int MDU_ON = 0;
`endif

    localparam int K_NOP  = 0;
    localparam int K_ADD  = 1;
    localparam int K_ORI  = 2;
    localparam int K_LUI  = 3;
    localparam int K_LW   = 4;
    localparam int K_SW   = 5;
    localparam int K_BEQ  = 6;
    localparam int K_JR   = 7;
    localparam int K_JALR = 8;
    localparam int K_JAL  = 9;
    localparam int K_MULT = 10;
    localparam int K_DIV  = 11;
    localparam int K_MFLO = 12;
    localparam int K_MTHI = 13;

    typedef struct {
        logic [31:0] word;
        int rs;
        int rt;
        int tuse_rs;   // -1: register not read
        int tuse_rt;
        int dest;
        int tnew;
        bit mdu;
        int lat;       // busy cycles started on issue, 0 if none
    } ins_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   cyc;

    // model: h_*[0] issued one cycle ago, h_*[1] two cycles ago
    int h_dest[2];
    int h_tnew[2];
    int mdu_issue;
    int mdu_lat_m;

    hazard_stall_ctrl_if bus ();

    hazard_stall_ctrl #(
        .MULT_LAT(MULT_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic ins_t mk(int kind, int a, int b, int c);
        ins_t r;
        r.word = 32'd0; r.rs = 0; r.rt = 0; r.tuse_rs = -1; r.tuse_rt = -1;
        r.dest = 0; r.tnew = 0; r.mdu = 1'b0; r.lat = 0;
        case (kind)
            K_ADD:  begin r.word = enc_r(b, c, a, 32); r.rs = b; r.rt = c; r.tuse_rs = 1; r.tuse_rt = 1; r.dest = a; r.tnew = 1; end
            K_ORI:  begin r.word = enc_i(13, b, a, c); r.rs = b; r.tuse_rs = 1; r.dest = a; r.tnew = 1; end
            K_LUI:  begin r.word = enc_i(15, 0, a, c); r.dest = a; r.tnew = 1; end
            K_LW:   begin r.word = enc_i(35, b, a, c); r.rs = b; r.tuse_rs = 1; r.dest = a; r.tnew = 2; end
            K_SW:   begin r.word = enc_i(43, b, a, c); r.rs = b; r.tuse_rs = 1; r.rt = a; r.tuse_rt = 2; end
            K_BEQ:  begin r.word = enc_i(4, a, b, c); r.rs = a; r.rt = b; r.tuse_rs = 0; r.tuse_rt = 0; end
            K_JR:   begin r.word = enc_r(a, 0, 0, 8); r.rs = a; r.tuse_rs = 0; end
            K_JALR: begin r.word = enc_r(b, 0, a, 9); r.rs = b; r.tuse_rs = 0; r.dest = a; r.tnew = 0; end
            K_JAL:  begin r.word = {6'd3, 26'(c)}; r.dest = 31; r.tnew = 0; end
            K_MULT: begin r.word = enc_r(a, b, 0, 24); r.rs = a; r.rt = b; r.tuse_rs = 1; r.tuse_rt = 1; r.mdu = 1'b1; r.lat = MULT_LAT; end
            K_DIV:  begin r.word = enc_r(a, b, 0, 26); r.rs = a; r.rt = b; r.tuse_rs = 1; r.tuse_rt = 1; r.mdu = 1'b1; r.lat = DIV_LAT; end
            K_MFLO: begin r.word = enc_r(0, 0, a, 18); r.dest = a; r.tnew = 1; r.mdu = 1'b1; end
            K_MTHI: begin r.word = enc_r(a, 0, 0, 17); r.rs = a; r.tuse_rs = 1; r.mdu = 1'b1; end
            default: r.word = 32'd0;
        endcase
        return r;
    endfunction

    // producer issued 'age' cycles ago still needs max(tnew-(age-1),0) cycles
    function automatic bit raw(int src, int tuse, int age);
        int rem;
        if (tuse < 0 || src == 0) return 1'b0;
        if (src != h_dest[age-1]) return 1'b0;
        rem = h_tnew[age-1] - (age - 1);
        if (rem < 0) rem = 0;
        return rem > tuse;
    endfunction

    function automatic bit model_busy();
        return (MDU_ON != 0) && (mdu_lat_m > 0) &&
               (cyc - mdu_issue >= 1) && (cyc - mdu_issue <= mdu_lat_m);
    endfunction

    function automatic bit model_stall(ins_t ins);
        return raw(ins.rs, ins.tuse_rs, 1) || raw(ins.rs, ins.tuse_rs, 2) ||
               raw(ins.rt, ins.tuse_rt, 1) || raw(ins.rt, ins.tuse_rt, 2) ||
               (model_busy() && ins.mdu);
    endfunction

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic do_reset(input int n);
        bus.instr_Id = 32'd0;
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
        h_dest[0] = 0; h_dest[1] = 0;
        h_tnew[0] = 0; h_tnew[1] = 0;
        mdu_lat_m = 0;
        cyc++;
    endtask

    // one clock with ins held in ID: check outputs mid-cycle, then advance the model
    task automatic cycle(input ins_t ins, output bit s_exp, output bit s_obs, output bit b_obs);
        bit b_exp;
        bus.instr_Id = ins.word;
        @(negedge clk);
        s_exp = model_stall(ins);
        b_exp = model_busy();
        s_obs = bus.ifStall;
        b_obs = bus.mduBusy;
        chk_bit("ifStall", bus.ifStall, s_exp);
        chk_bit("idExFlush", bus.idExFlush, s_exp);
        chk_bit("mduBusy", bus.mduBusy, b_exp);
        h_dest[1] = h_dest[0];
        h_tnew[1] = h_tnew[0];
        if (s_exp) begin
            h_dest[0] = 0;
            h_tnew[0] = 0;
        end else begin
            h_dest[0] = ins.dest;
            h_tnew[0] = ins.tnew;
            if (ins.lat > 0) begin
                mdu_issue = cyc;
                mdu_lat_m = ins.lat;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // hold ins in ID until the model lets it issue; returns observed stall/busy cycle counts
    task automatic issue(input ins_t ins, output int n_stall, output int n_busy);
        bit done, s_exp, s_obs, b_obs;
        n_stall = 0;
        n_busy  = 0;
        done    = 1'b0;
        for (int k = 0; k < 24; k++) begin
            cycle(ins, s_exp, s_obs, b_obs);
            n_stall += int'(s_obs);
            n_busy  += int'(b_obs);
            if (!s_exp) begin
                done = 1'b1;
                break;
            end
        end
        chk_bit("issue_bound", done, 1'b1);
    endtask

    task automatic pair(input string tag, input ins_t prod, input ins_t cons, input int exp_stalls);
        int ns, nb;
        ins_t nop_i;
        nop_i = mk(K_NOP, 0, 0, 0);
        issue(nop_i, ns, nb);
        issue(nop_i, ns, nb);
        issue(prod, ns, nb);
        issue(cons, ns, nb);
        chk_int(tag, ns, exp_stalls);
    endtask

    function automatic int rreg();
        int v;
        v = int'($urandom_range(0, 5));
        return (v == 5) ? 31 : v;
    endfunction

    initial begin
        int ns, nb;
        ins_t nop_i;
        ins_t ri;
        total = 0;
        bad   = 0;
        cyc   = 0;
        mdu_issue = 0;
        mdu_lat_m = 0;
        h_dest[0] = 0; h_dest[1] = 0;
        h_tnew[0] = 0; h_tnew[1] = 0;
        nop_i = mk(K_NOP, 0, 0, 0);

        do_reset(2);
        issue(nop_i, ns, nb);
        chk_int("rst_stall", ns, 0);
        chk_int("rst_busy", nb, 0);

        pair("load_use", mk(K_LW, 8, 0, 0), mk(K_ADD, 9, 8, 8), 1);
        pair("alu_branch", mk(K_ORI, 8, 0, 1), mk(K_BEQ, 8, 0, 3), 1);
        pair("load_branch", mk(K_LW, 8, 0, 0), mk(K_BEQ, 8, 0, 3), 2);
        pair("load_store_data", mk(K_LW, 8, 0, 0), mk(K_SW, 8, 0, 4), 0);
        pair("zero_dest", mk(K_ORI, 0, 0, 1), mk(K_ADD, 9, 0, 0), 0);
        pair("alu_jr", mk(K_ORI, 31, 0, 7), mk(K_JR, 31, 0, 0), 1);
        pair("jal_jr", mk(K_JAL, 0, 0, 16), mk(K_JR, 31, 0, 0), 0);

        issue(mk(K_MULT, 8, 9, 0), ns, nb);
        issue(mk(K_MFLO, 10, 0, 0), ns, nb);
        chk_int("mult_stall", ns, (MDU_ON != 0) ? MULT_LAT : 0);
        chk_int("mult_busy", nb, (MDU_ON != 0) ? MULT_LAT : 0);

        issue(mk(K_DIV, 8, 9, 0), ns, nb);
        issue(mk(K_MFLO, 10, 0, 0), ns, nb);
        chk_int("div_stall", ns, (MDU_ON != 0) ? DIV_LAT : 0);
        chk_int("div_busy", nb, (MDU_ON != 0) ? DIV_LAT : 0);

        issue(mk(K_DIV, 8, 9, 0), ns, nb);
        issue(nop_i, ns, nb);
        issue(nop_i, ns, nb);
        do_reset(1);
        issue(mk(K_MFLO, 10, 0, 0), ns, nb);
        chk_int("midop_rst_stall", ns, 0);
        chk_int("midop_rst_busy", nb, 0);

        for (int i = 0; i < 300; i++) begin
            ri = mk(int'($urandom_range(0, 13)), rreg(), rreg(), int'($urandom_range(0, 255)));
            issue(ri, ns, nb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
